uart_rx_cfg: RTL and testbench

- Parametrised, runtime-configurable successor to the UART receiver: oversampled serial input, 5..DATA_SIZE data bits, optional even/odd parity, 1 or 2 stop bits.
- Holds a received word with valid/acknowledge handshake so overflow is well defined.
- Sits between the pad-side serial line and the register/FIFO interface of the UART block.
- Clocked by the oversample clock: OVERSAMPLE clk cycles per bit.

---
 rtl/uart_rx_cfg.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable oversampled UART receiver; RX_MAJORITY_VOTE_EN adds 2-of-3 bit voting
module uart_rx_cfg #(
    parameter int DATA_SIZE      = 8,
    parameter int OVERSAMPLE     = 16,
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx_start_n,
    input  logic                      serial_data_in,
    input  logic [BIT_COUNT_SIZE-1:0] cfg_data_bits,
    input  logic                      cfg_parity_en,
    input  logic                      cfg_parity_odd,
    input  logic                      cfg_stop2,
    input  logic                      rd_ack,
    output logic [DATA_SIZE-1:0]      data_out,
    output logic                      data_valid,
    output logic                      rx_done,
    output logic                      parity_error,
    output logic                      stop_error,
    output logic                      break_error,
    output logic                      overflow_error
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_COUNT_SIZE-1:0] MIN_BITS = BIT_COUNT_SIZE'(5);
    localparam logic [BIT_COUNT_SIZE-1:0] MAX_BITS = BIT_COUNT_SIZE'(DATA_SIZE);
    localparam logic [BIT_COUNT_SIZE-1:0] ONE_BIT  = BIT_COUNT_SIZE'(1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                    state;
    logic                      rx_meta, rxs, rxs_d;
    logic [CNT_W-1:0]          cnt;
    logic [BIT_COUNT_SIZE-1:0] bit_idx, nbits, eff_bits;
    logic                      par_en, par_odd, stop2, second_stop;
    logic [DATA_SIZE-1:0]      shreg;
    logic                      par_acc, par_bad, stop_bad, all_zero, brk_flag;
    logic                      bit_val, decide, frame_stop_bad, frame_brk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= serial_data_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a, vote_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (cnt == CNT_W'(OVERSAMPLE / 2 - 2)) vote_a <= rxs;
            if (cnt == CNT_W'(OVERSAMPLE / 2 - 1)) vote_b <= rxs;
        end
    end

    assign bit_val = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
`else
    assign bit_val = rxs;
`endif

    assign decide   = (cnt == DECIDE_PT);
    assign eff_bits = (cfg_data_bits < MIN_BITS || cfg_data_bits > MAX_BITS) ? MAX_BITS : cfg_data_bits;
    // Break is judged on the first stop bit even when a second one follows.
    assign frame_stop_bad = stop_bad | ~bit_val;
    assign frame_brk      = second_stop ? brk_flag : (all_zero & ~bit_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            nbits          <= '0;
            par_en         <= 1'b0;
            par_odd        <= 1'b0;
            stop2          <= 1'b0;
            second_stop    <= 1'b0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            par_bad        <= 1'b0;
            stop_bad       <= 1'b0;
            all_zero       <= 1'b0;
            brk_flag       <= 1'b0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            rx_done        <= 1'b0;
            parity_error   <= 1'b0;
            stop_error     <= 1'b0;
            break_error    <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            if (rd_ack) begin
                data_valid     <= 1'b0;
                overflow_error <= 1'b0;
            end
            if (rx_start_n) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxs_d && !rxs) begin
                            state   <= START;
                            cnt     <= '0;
                            nbits   <= eff_bits;
                            par_en  <= cfg_parity_en;
                            par_odd <= cfg_parity_odd;
                            stop2   <= cfg_stop2;
                        end
                    end
                    START: begin
                        // The free-running counter wraps, so the next decision lands one bit later.
                        if (decide) begin
                            if (bit_val) begin
                                state <= IDLE;
                            end else begin
                                state       <= DATA;
                                bit_idx     <= '0;
                                shreg       <= '0;
                                par_acc     <= 1'b0;
                                par_bad     <= 1'b0;
                                stop_bad    <= 1'b0;
                                all_zero    <= 1'b1;
                                second_stop <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (decide) begin
                            shreg   <= shreg | (DATA_SIZE'(bit_val) << bit_idx);
                            par_acc <= par_acc ^ bit_val;
                            if (bit_val) all_zero <= 1'b0;
                            if (bit_idx == nbits - ONE_BIT) begin
                                state <= par_en ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + ONE_BIT;
                            end
                        end
                    end
                    PARITY: begin
                        if (decide) begin
                            par_bad <= (bit_val != (par_acc ^ par_odd));
                            if (bit_val) all_zero <= 1'b0;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (decide) begin
                            if (stop2 && !second_stop) begin
                                second_stop <= 1'b1;
                                stop_bad    <= ~bit_val;
                                brk_flag    <= all_zero & ~bit_val;
                            end else begin
                                rx_done        <= 1'b1;
                                data_valid     <= 1'b1;
                                overflow_error <= data_valid & ~rd_ack;
                                data_out       <= frame_brk ? '0 : shreg;
                                parity_error   <= par_bad & ~frame_brk;
                                stop_error     <= frame_stop_bad;
                                break_error    <= frame_brk;
                                state          <= frame_brk ? BRK_WAIT : IDLE;
                            end
                        end
                    end
                    BRK_WAIT: begin
                        if (rxs) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg with a frame-level reference model
module tb_uart_rx_cfg;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n, rx_start_n, serial_data_in;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en, cfg_parity_odd, cfg_stop2, rd_ack;
    logic [7:0] data_out;
    logic       data_valid, rx_done, parity_error, stop_error, break_error, overflow_error;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_SIZE(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset_n(reset_n), .rx_start_n(rx_start_n), .serial_data_in(serial_data_in),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .rd_ack(rd_ack), .data_out(data_out), .data_valid(data_valid),
        .rx_done(rx_done), .parity_error(parity_error), .stop_error(stop_error),
        .break_error(break_error), .overflow_error(overflow_error)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic       brk;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   model_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rx_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rx_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("data_valid", 32'(data_valid), 32'd1);
                chk("parity_error", 32'(parity_error), 32'(e.par));
                chk("stop_error", 32'(stop_error), 32'(e.stp));
                chk("break_error", 32'(break_error), 32'(e.brk));
                chk("overflow_error", 32'(overflow_error), 32'(e.ovf));
            end
        end
    end

    task automatic line(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_data_in = v;
        end
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic pen, input logic podd, input logic st2);
        cfg_data_bits = nb;
        cfg_parity_en = pen;
        cfg_parity_odd = podd;
        cfg_stop2 = st2;
    endtask

    task automatic ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("valid_after_ack", 32'(data_valid), 32'd0);
        chk("overflow_after_ack", 32'(overflow_error), 32'd0);
        model_valid = 1'b0;
    endtask

    // Transmit one frame; expected word is derived from the frame rules. exp_flip marks
    // bits the receiver is expected to see inverted because of a deliberate glitch.
    task automatic send_frame(input logic [7:0] data, input logic [3:0] nb, input logic pen,
                              input logic podd, input logic st2, input logic flip,
                              input logic [1:0] stops, input int gap_bits, input int glitch,
                              input logic [7:0] exp_flip);
        int   eff, cyc, gap;
        logic [7:0] d;
        logic good, pbit, brk, last_stop;
        logic bits[$];
        exp_t e;
        eff  = (nb < 4'd5 || nb > 4'd8) ? 8 : int'(nb);
        d    = data & 8'((1 << eff) - 1);
        good = logic'($countones(d) % 2) ^ podd;
        pbit = good ^ flip;
        brk  = (d == 8'd0) && (!pen || !pbit) && !stops[0];
        e.data = brk ? 8'd0 : (d ^ exp_flip);
        e.par  = !brk && pen && (pbit != good);
        e.stp  = !stops[0] || (st2 && !stops[1]);
        e.brk  = brk;
        e.ovf  = model_valid;
        exp_q.push_back(e);
        model_valid = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < eff; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stops[0]);
        if (st2) bits.push_back(stops[1]);
        last_stop = st2 ? stops[1] : stops[0];
        cyc = 0;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < OS; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) set_cfg(nb, pen, podd, st2);
                if (b == 2 && c == 0) set_cfg(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                serial_data_in = bits[b] ^ (cyc == glitch);
                cyc++;
            end
        end
        gap = (!last_stop && gap_bits < 1) ? 1 : gap_bits;
        line(1'b1, gap * OS);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rs;
        reset_n = 1'b0;
        rx_start_n = 1'b0;
        serial_data_in = 1'b1;
        rd_ack = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_parity", 32'(parity_error), 32'd0);
        chk("rst_stop", 32'(stop_error), 32'd0);
        chk("rst_break", 32'(break_error), 32'd0);
        chk("rst_overflow", 32'(overflow_error), 32'd0);
        reset_n = 1'b1;
        line(1'b1, 2 * OS);

        send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, -1, 8'h00);
        ack();
        send_frame(8'h35, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1, -1, 8'h00);
        ack();
        send_frame(8'h35, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1, -1, 8'h00);
        ack();
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, -1, 8'h00);
        ack();

        // Line held low for 12 bit times: exactly one break frame, nothing more until high.
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{data: 8'h00, par: 1'b0, stp: 1'b1, brk: 1'b1, ovf: model_valid});
        model_valid = 1'b1;
        line(1'b0, 12 * OS);
        line(1'b1, 2 * OS);
        ack();

        send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, -1, 8'h00);
        send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, -1, 8'h00);
        ack();

        line(1'b0, OS / 4);
        line(1'b1, 2 * OS);

        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        line(1'b0, OS);
        line(1'b1, OS);
        line(1'b0, OS);
        @(negedge clk);
        rx_start_n = 1'b1;
        line(1'b1, 2 * OS);
        rx_start_n = 1'b0;
        line(1'b1, OS);
        send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, -1, 8'h00);
        ack();

`ifdef RX_MAJORITY_VOTE_EN
        send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, 4 * OS + OS / 2, 8'h00);
`else
        send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, 4 * OS + OS / 2, 8'h08);
`endif
        ack();

        for (int k = 0; k < 40; k++) begin
            rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rs[0] = ($urandom_range(0, 5) != 0);
            rs[1] = ($urandom_range(0, 5) != 0);
            send_frame(rd, 4'($urandom_range(3, 10)), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), rs, $urandom_range(0, 2), -1, 8'h00);
            if ($urandom_range(0, 2) == 0) ack();
        end

        line(1'b1, 3 * OS);
        chk("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
